d1_read_ctrl: RTL and testbench
===============================

# d1_read_ctrl

Read-side controller directly downstream of the D1 data FIFO in the PCIe transmission-layer datapath. It pops words from the D1 FIFO whenever the FIFO holds data and the next stage is not asserting backpressure. It absorbs the FIFO's one-cycle registered read latency and presents each word to the next stage as a registered data/valid pair. A small state machine tracks reset/init, idle and active draining, and latches a sticky error when the FIFO flags overflow.

## Interface
Parameters:
- data_width, 6, width of a D1 FIFO word.
- count_width, 8, width of the forwarded-word counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  synchronous re-initialise when 0; same signal that feeds the D1 FIFO.
- empty_fifo_D1  in  1  D1 FIFO empty flag.
- error_D1  in  1  D1 FIFO overflow/error flag.
- data_out_D1  in  data_width  D1 FIFO read data; valid the cycle after a pop, 0 otherwise.
- pause_in  in  1  backpressure from the next stage (its almost-full); 1 = do not pop.
- rd_enable_D1  out  1  pop request to the D1 FIFO (combinational).
- data_out  out  data_width  word forwarded to the next stage (registered).
- valid_out  out  1  data_out holds a forwarded word this cycle (registered).
- word_count  out  count_width  words forwarded since last reset/init; wraps.
- error_out  out  1  sticky error indication.
- idle_out  out  1  IDLE state and no pop in flight.
- state  out  2  current FSM state encoding.

## Operation
- States: RESET=2'd0, IDLE=2'd1, ACTIVE=2'd2, ERROR=2'd3.
- Transitions, evaluated each edge, first match wins:
  - init==0: any state -> RESET.
  - RESET -> IDLE when init==1.
  - IDLE/ACTIVE -> ERROR when error_D1==1.
  - IDLE -> ACTIVE when empty_fifo_D1==0.
  - ACTIVE -> IDLE when empty_fifo_D1==1.
  - ERROR holds until init==0 or reset_L==0.
- rd_enable_D1 = (state==ACTIVE) & ~empty_fifo_D1 & ~pause_in & ~error_D1. Never asserted in RESET, IDLE or ERROR.
- Internal flag pop_d <= rd_enable_D1; it marks that data_out_D1 is valid in the current cycle.
- Forwarding register:
  - valid_out <= pop_d.
  - data_out <= pop_d ? data_out_D1 : 0.
- word_count increments by 1 each cycle valid_out is set. Modulo 2^count_width: 255 -> 0 with the default width.
- error_out = (state==ERROR).
- idle_out = (state==IDLE) & ~pop_d & ~valid_out.
- A pop issued in the cycle before a transition to IDLE or ERROR still completes: its word is forwarded normally.
- init==0 clears, on that edge: pop_d, valid_out, data_out, word_count and state. The in-flight word is discarded, because the FIFO is also flushed by init.

## Timing
- Asynchronous reset (reset_L==0) values: state=RESET, pop_d=0, valid_out=0, data_out=0, word_count=0, error_out=0, idle_out=0, rd_enable_D1=0.
- Latency: rd_enable_D1 high in cycle N -> data_out_D1 valid in N+1 -> data_out/valid_out in N+2.
- Throughput: one word per cycle while ACTIVE, not empty and not paused.
- pause_in is honoured combinationally in the same cycle. Words already popped, at most one, are still forwarded; the next stage's almost-full margin must cover 2 words.
- Empty flag updates on the same edge as the FIFO pop, so no pop is ever issued against an empty FIFO.
- Error path: error_D1 seen at edge E -> state=ERROR after E. rd_enable_D1 is 0 in every cycle error_D1 is 1.
- Reset deasserted with init==1: RESET -> IDLE on the first edge.

## Test plan
- Reset then init=1, FIFO empty -> state RESET->IDLE in 1 cycle, idle_out=1, rd_enable_D1=0, data_out=0.
- Write 3 words 0x05,0x2A,0x3F into D1, pause_in=0 -> three consecutive rd_enable_D1 pulses. valid_out high 3 cycles, starting 2 cycles after the first pop, with data 0x05,0x2A,0x3F. word_count=3, then state returns to IDLE.
- Fill FIFO to 4 and hold pause_in=1 for 5 cycles -> no pops, valid_out=0. Release pause_in -> 4 words forwarded back-to-back in order.
- Toggle pause_in every cycle with the FIFO full -> pops only in unpaused cycles, no word lost or duplicated, order preserved.
- Force error_D1=1 for one cycle in ACTIVE -> state=ERROR, error_out=1 and stays 1. rd_enable_D1=0 thereafter. Recovers to RESET then IDLE only after init pulses 0 then 1.
- Drop init mid-burst, and separately assert reset_L=0 mid-cycle -> outputs clear per the reset/init rules: valid_out=0, word_count=0, state=RESET. Forward 256 words afterwards -> word_count wraps to 0.

Source files
------------

// File: rtl/d1_read_ctrl.sv
// D1 FIFO read-side controller. It pops the FIFO while data is available and
// the next stage is not applying backpressure. It absorbs the FIFO's one-cycle
// read latency, forwards each word as a registered data/valid pair, and
// latches a sticky error when the FIFO reports an overflow.
module d1_read_ctrl #(
  parameter int unsigned data_width  = 6,
  parameter int unsigned count_width = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  input  logic                   init,
  input  logic                   empty_fifo_D1,
  input  logic                   error_D1,
  input  logic [data_width-1:0]  data_out_D1,
  input  logic                   pause_in,
  output logic                   rd_enable_D1,
  output logic [data_width-1:0]  data_out,
  output logic                   valid_out,
  output logic [count_width-1:0] word_count,
  output logic                   error_out,
  output logic                   idle_out,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   pop_d;
  logic                   pop_n;
  logic                   valid_n;
  logic                   error_n;
  logic                   idle_n;
  logic [data_width-1:0]  data_n;
  logic [count_width-1:0] count_n;

  // State register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, pop request, and next values of the forwarding stage
  always_comb begin
    state_d      = state_q;
    rd_enable_D1 = 1'b0;
    pop_n        = 1'b0;
    valid_n      = 1'b0;
    data_n       = '0;
    count_n      = word_count;
    error_n      = 1'b0;
    idle_n       = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (error_D1)           state_d = ST_ERROR;
        else if (!empty_fifo_D1) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        rd_enable_D1 = !empty_fifo_D1 && !pause_in && !error_D1;
        if (error_D1)           state_d = ST_ERROR;
        else if (empty_fifo_D1) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    // A pop from the previous cycle completes even if the state leaves ACTIVE now
    pop_n   = rd_enable_D1;
    valid_n = pop_d;
    data_n  = pop_d ? data_out_D1 : '0;
    count_n = pop_d ? word_count + count_width'(1) : word_count;

    // init low flushes the FIFO too, so the in-flight word is discarded
    if (!init) begin
      state_d = ST_RESET;
      pop_n   = 1'b0;
      valid_n = 1'b0;
      data_n  = '0;
      count_n = '0;
    end

    error_n = (state_d == ST_ERROR);
    idle_n  = (state_d == ST_IDLE) && !pop_n && !valid_n;
  end

  // Forwarding stage and status registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_d      <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      word_count <= '0;
      error_out  <= 1'b0;
      idle_out   <= 1'b0;
    end else begin
      pop_d      <= pop_n;
      valid_out  <= valid_n;
      data_out   <= data_n;
      word_count <= count_n;
      error_out  <= error_n;
      idle_out   <= idle_n;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_d1_read_ctrl.sv
// Self-checking bench for d1_read_ctrl. It uses a behavioural D1 FIFO with a
// one-cycle registered read and an in-order scoreboard of forwarded words.
`timescale 1ns/1ps
module tb_d1_read_ctrl;
  localparam int unsigned DW = 6;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init;
  logic          empty_fifo_D1;
  logic          error_D1;
  logic [DW-1:0] data_out_D1;
  logic          pause_in;
  logic          rd_enable_D1;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [CW-1:0] word_count;
  logic          error_out;
  logic          idle_out;
  logic [1:0]    state;

  logic          wr_en;
  logic [DW-1:0] wr_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int init_base = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            rd_cyc[$];
  int            val_cyc[$];

  d1_read_ctrl #(.data_width(DW), .count_width(CW)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .empty_fifo_D1(empty_fifo_D1),
    .error_D1(error_D1), .data_out_D1(data_out_D1), .pause_in(pause_in),
    .rd_enable_D1(rd_enable_D1), .data_out(data_out), .valid_out(valid_out),
    .word_count(word_count), .error_out(error_out), .idle_out(idle_out),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // D1 FIFO model: one write port, registered read data, flushed by init/reset
  always @(posedge clk or negedge reset_L) begin
    if (!reset_L || !init) begin
      fifo_q.delete();
      data_out_D1   <= '0;
      empty_fifo_D1 <= 1'b1;
    end else begin
      if (rd_enable_D1) data_out_D1 <= fifo_q.pop_front();
      else              data_out_D1 <= '0;
      if (wr_en) fifo_q.push_back(wr_data);
      empty_fifo_D1 <= (fifo_q.size() == 0);
    end
  end

  // Record the forwarded stream and the pop/valid timing
  always @(negedge clk) begin
    if (valid_out) begin
      got_q.push_back(data_out);
      val_cyc.push_back(cyc);
    end
    if (rd_enable_D1) rd_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    pause_in = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (fifo_q.size() == 0 && idle_out === 1'b1 && state === 2'd1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_L = 1'b0; init = 1'b0; wr_en = 1'b0; wr_data = '0;
    pause_in = 1'b0; error_D1 = 1'b0;
    repeat (2) tick();
    checks++;
    if ({state, valid_out, data_out, word_count, error_out, idle_out, rd_enable_D1} !==
        {2'd0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values state=%0d valid=%b data=%h cnt=%0d err=%b idle=%b rd=%b required all zero",
               state, valid_out, data_out, word_count, error_out, idle_out, rd_enable_D1);
    end
    reset_L = 1'b1; init = 1'b1;
    tick();
    init_base = got_q.size();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL reset_to_idle state=%0d required 1", state); end
    checks++;
    if (idle_out !== 1'b1 || rd_enable_D1 !== 1'b0 || data_out !== '0) begin
      errors++;
      $display("FAIL idle_outputs idle=%b rd=%b data=%h required 1 0 00", idle_out, rd_enable_D1, data_out);
    end
  endtask

  task automatic test_basic();
    int gb, rb, vb; bit ok;
    exp_q.delete(); gb = got_q.size(); rb = rd_cyc.size(); vb = val_cyc.size();
    pause_in = 1'b0;
    push_word(6'h05); push_word(6'h2A); push_word(6'h3F);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_drain timeout state=%0d", state); end
    checks++;
    if (got_q.size() - gb !== 3 || rd_cyc.size() - rb !== 3) begin
      errors++;
      $display("FAIL basic_len words=%0d pops=%0d required 3 3", got_q.size() - gb, rd_cyc.size() - rb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[gb+i] !== exp_q[i] || rd_cyc[rb+i] !== rd_cyc[rb] + i ||
            val_cyc[vb+i] !== rd_cyc[rb+i] + 2) begin
          errors++;
          $display("FAIL basic_word%0d data=%h pop_cyc=%0d val_cyc=%0d required data=%h pop_cyc=%0d val_cyc=%0d",
                   i, got_q[gb+i], rd_cyc[rb+i], val_cyc[vb+i], exp_q[i], rd_cyc[rb] + i, rd_cyc[rb+i] + 2);
        end
      end
    end
    checks++;
    if (word_count !== 8'd3) begin errors++; $display("FAIL basic_count cnt=%0d required 3", word_count); end
  endtask

  task automatic test_pause();
    int gb, vb; bit ok;
    exp_q.delete(); gb = got_q.size();
    pause_in = 1'b1;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rd_enable_D1 !== 1'b0 || valid_out !== 1'b0 || data_out !== '0) begin
        errors++;
        $display("FAIL pause_hold%0d rd=%b valid=%b data=%h required 0 0 00", i, rd_enable_D1, valid_out, data_out);
      end
      tick();
    end
    vb = val_cyc.size();
    drain(ok);
    checks++;
    if (!ok || got_q.size() - gb !== 4) begin
      errors++;
      $display("FAIL pause_release ok=%0d words=%0d required 1 4", ok, got_q.size() - gb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[gb+i] !== exp_q[i] || val_cyc[vb+i] !== val_cyc[vb] + i) begin
          errors++;
          $display("FAIL pause_word%0d data=%h cyc=%0d required %h cyc=%0d",
                   i, got_q[gb+i], val_cyc[vb+i], exp_q[i], val_cyc[vb] + i);
        end
      end
    end
    checks++;
    if (word_count !== CW'(got_q.size() - init_base)) begin
      errors++; $display("FAIL pause_count cnt=%0d required %0d", word_count, CW'(got_q.size() - init_base));
    end
  endtask

  task automatic test_toggle();
    int gb; bit ok;
    exp_q.delete(); gb = got_q.size();
    pause_in = 1'b1;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    for (int i = 0; i < 20; i++) begin
      pause_in = ~pause_in;
      #1;
      checks++;
      if (pause_in && rd_enable_D1 !== 1'b0) begin
        errors++; $display("FAIL toggle_pop_while_paused cyc=%0d rd=%b required 0", cyc, rd_enable_D1);
      end
      tick();
    end
    drain(ok);
    checks++;
    if (!ok || got_q.size() - gb !== exp_q.size()) begin
      errors++;
      $display("FAIL toggle_len ok=%0d words=%0d required 1 %0d", ok, got_q.size() - gb, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[gb+i] !== exp_q[i]) begin
          errors++; $display("FAIL toggle_word%0d data=%h required %h", i, got_q[gb+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int gb; bit ok;
    exp_q.delete(); gb = got_q.size();
    for (int i = 0; i < 250; i++) begin
      pause_in = ($urandom_range(3) == 0);
      if ($urandom_range(2) != 0) begin
        wr_en = 1'b1; wr_data = DW'($urandom); exp_q.push_back(wr_data);
      end else begin
        wr_en = 1'b0;
      end
      #1;
      checks++;
      if (pause_in && rd_enable_D1 !== 1'b0) begin
        errors++; $display("FAIL random_pop_while_paused cyc=%0d rd=%b required 0", cyc, rd_enable_D1);
      end
      tick();
    end
    wr_en = 1'b0;
    drain(ok);
    checks++;
    if (!ok || got_q.size() - gb !== exp_q.size()) begin
      errors++;
      $display("FAIL random_len ok=%0d words=%0d required 1 %0d", ok, got_q.size() - gb, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[gb+i] !== exp_q[i]) begin
          errors++; $display("FAIL random_word%0d data=%h required %h", i, got_q[gb+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (word_count !== CW'(got_q.size() - init_base)) begin
      errors++; $display("FAIL random_count cnt=%0d required %0d", word_count, CW'(got_q.size() - init_base));
    end
  endtask

  task automatic test_error();
    exp_q.delete();
    pause_in = 1'b1;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    pause_in = 1'b0;
    #1;
    checks++;
    if (rd_enable_D1 !== 1'b1) begin errors++; $display("FAIL error_prepop rd=%b required 1", rd_enable_D1); end
    tick();
    error_D1 = 1'b1;
    #1;
    checks++;
    if (rd_enable_D1 !== 1'b0) begin errors++; $display("FAIL error_rd_gate rd=%b required 0", rd_enable_D1); end
    tick();
    error_D1 = 1'b0;
    checks++;
    if (state !== 2'd3 || error_out !== 1'b1 || valid_out !== 1'b1 || data_out !== exp_q[0]) begin
      errors++;
      $display("FAIL error_enter state=%0d err=%b valid=%b data=%h required 3 1 1 %h",
               state, error_out, valid_out, data_out, exp_q[0]);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (state !== 2'd3 || error_out !== 1'b1 || rd_enable_D1 !== 1'b0) begin
        errors++;
        $display("FAIL error_sticky%0d state=%0d err=%b rd=%b required 3 1 0", i, state, error_out, rd_enable_D1);
      end
    end
    checks++;
    if (word_count !== CW'(got_q.size() - init_base)) begin
      errors++; $display("FAIL error_count cnt=%0d required %0d", word_count, CW'(got_q.size() - init_base));
    end
    init = 1'b0;
    tick();
    checks++;
    if (state !== 2'd0 || error_out !== 1'b0 || word_count !== '0) begin
      errors++; $display("FAIL error_init state=%0d err=%b cnt=%0d required 0 0 0", state, error_out, word_count);
    end
    init = 1'b1;
    init_base = got_q.size();
    tick();
    checks++;
    if (state !== 2'd1 || idle_out !== 1'b1) begin
      errors++; $display("FAIL error_recover state=%0d idle=%b required 1 1", state, idle_out);
    end
  endtask

  task automatic test_init_midburst();
    int gb;
    exp_q.delete(); gb = got_q.size();
    pause_in = 1'b0;
    for (int i = 0; i < 6; i++) push_word(DW'($urandom));
    init = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b0 || word_count !== '0 || state !== 2'd0 || data_out !== '0) begin
      errors++;
      $display("FAIL init_clear valid=%b cnt=%0d state=%0d data=%h required 0 0 0 00",
               valid_out, word_count, state, data_out);
    end
    checks++;
    if (got_q.size() - gb < 1 || got_q.size() - gb > exp_q.size()) begin
      errors++; $display("FAIL init_prefix_len words=%0d required 1..%0d", got_q.size() - gb, exp_q.size());
    end else begin
      for (int i = 0; i < got_q.size() - gb; i++) begin
        checks++;
        if (got_q[gb+i] !== exp_q[i]) begin
          errors++; $display("FAIL init_prefix%0d data=%h required %h", i, got_q[gb+i], exp_q[i]);
        end
      end
    end
    init_base = got_q.size();
    init = 1'b1;
    tick();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL init_recover state=%0d required 1", state); end
  endtask

  task automatic test_async_reset();
    exp_q.delete();
    pause_in = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DW'($urandom));
    #3;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({state, valid_out, data_out, word_count, error_out, idle_out, rd_enable_D1} !==
        {2'd0, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset state=%0d valid=%b data=%h cnt=%0d err=%b idle=%b rd=%b required all zero",
               state, valid_out, data_out, word_count, error_out, idle_out, rd_enable_D1);
    end
    tick();
    init_base = got_q.size();
    reset_L = 1'b1;
    tick();
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL async_recover state=%0d required 1", state); end
  endtask

  task automatic test_wrap();
    int gb; bit ok;
    exp_q.delete(); gb = got_q.size();
    pause_in = 1'b0;
    for (int i = 0; i < 256; i++) push_word(DW'($urandom));
    drain(ok);
    checks++;
    if (!ok || got_q.size() - gb !== 256) begin
      errors++; $display("FAIL wrap_len ok=%0d words=%0d required 1 256", ok, got_q.size() - gb);
    end else begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if (got_q[gb+i] !== exp_q[i]) begin
          errors++; $display("FAIL wrap_word%0d data=%h required %h", i, got_q[gb+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (word_count !== 8'd0) begin errors++; $display("FAIL wrap_count cnt=%0d required 0", word_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_toggle();
    test_random();
    test_error();
    test_init_midburst();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
